// File: rtl/pia_kbd_dsp.sv
// Apple-1 PIA keyboard/display register block: key type-ahead FIFO in,
// display character out over valid/ready, with KBD/KBDCR/DSP/DSPCR polling registers.
module pia_kbd_dsp #(
    parameter int KEY_FIFO_DEPTH = 4,
    parameter int UPPERCASE      = 1
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       enable,
    input  logic       cs,
    input  logic [1:0] address,
    input  logic       w_en,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       key_valid,
    input  logic [6:0] key_data,
    output logic       key_ready,
    output logic       dsp_valid,
    output logic [6:0] dsp_data,
    input  logic       dsp_ready
);
    localparam int PW = (KEY_FIFO_DEPTH > 1) ? $clog2(KEY_FIFO_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = (PW+1)'(KEY_FIFO_DEPTH);

    logic [6:0]    mem [KEY_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [6:0]    last_key;
    logic [6:0]    kbdcr;
    logic [5:0]    dspcr;
    logic          ovf, drop, busy;

    logic       rd, wr, empty, full, push, pop;
    logic       dsp_wr, dsp_accept;
    logic [6:0] key_in, head;

    assign rd    = cs & enable & ~w_en;
    assign wr    = cs & enable & w_en;
    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign head  = mem[rd_ptr];

    // A pop frees a slot in the same edge, so a key arriving while full is
    // still taken when the CPU reads KBD in that cycle.
    assign pop   = rd & (address == 2'd0) & ~empty;
    assign push  = key_valid & (~full | pop);

    assign key_in = ((UPPERCASE != 0) && (key_data >= 7'h61) && (key_data <= 7'h7A))
                    ? key_data - 7'h20 : key_data;

    assign dsp_wr     = wr & (address == 2'd2);
    assign dsp_accept = busy & dsp_ready;

    assign key_ready = ~full;
    assign dsp_valid = busy;

    always_ff @(posedge clk25) begin
        if (push) mem[wr_ptr] <= key_in;
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_key <= 7'h00;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                last_key <= head;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            kbdcr    <= '0;
            dspcr    <= '0;
            ovf      <= 1'b0;
            drop     <= 1'b0;
            busy     <= 1'b0;
            dsp_data <= '0;
        end else begin
            if (wr && address == 2'd1) kbdcr <= din[6:0];
            // Clearing comes first so an event in the same cycle stays visible.
            if (wr && address == 2'd3) begin
                dspcr <= din[5:0];
                ovf   <= 1'b0;
                drop  <= 1'b0;
            end
            if (key_valid && full && !pop) ovf <= 1'b1;
            if (dsp_accept) busy <= 1'b0;
            if (dsp_wr) begin
                if (busy) drop <= 1'b1;
                else begin
                    dsp_data <= din[6:0];
                    busy     <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        dout = 8'h00;
        case (address)
            2'd0: dout = empty ? {1'b0, last_key} : {1'b1, head};
            2'd1: dout = {~empty, kbdcr};
            2'd2: dout = {busy, dsp_data};
            2'd3: dout = {ovf, drop, dspcr};
            default: dout = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_pia_kbd_dsp.sv
// Directed self-checking bench for pia_kbd_dsp (depth 4, uppercase folding on).
module tb_pia_kbd_dsp;
    logic       clk25 = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       cs = 1'b0;
    logic [1:0] address = 2'd0;
    logic       w_en = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       key_valid = 1'b0;
    logic [6:0] key_data = 7'h00;
    logic       key_ready;
    logic       dsp_valid;
    logic [6:0] dsp_data;
    logic       dsp_ready = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    pia_kbd_dsp #(.KEY_FIFO_DEPTH(4), .UPPERCASE(1)) dut (
        .clk25(clk25), .rst(rst), .enable(enable), .cs(cs), .address(address),
        .w_en(w_en), .din(din), .dout(dout), .key_valid(key_valid),
        .key_data(key_data), .key_ready(key_ready), .dsp_valid(dsp_valid),
        .dsp_data(dsp_data), .dsp_ready(dsp_ready)
    );

    always #20 clk25 = ~clk25;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push_key(input logic [6:0] k);
        key_valid = 1'b1;
        key_data  = k;
        @(posedge clk25); #1;
        key_valid = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
        cs = 1'b1; w_en = 1'b0; address = a;
        #5 d = dout;
        @(posedge clk25); #1;
        cs = 1'b0;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; w_en = 1'b1; address = a; din = d;
        @(posedge clk25); #1;
        cs = 1'b0; w_en = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_rd(a, d);
        chk(tag, {24'h0, d}, {24'h0, exp});
    endtask

    initial begin
        logic [7:0] d;
        // 1: reset state, all addresses read zero
        #5;
        for (int i = 0; i < 4; i++) begin
            address = 2'(i);
            #1 chk($sformatf("rst_dout%0d", i), {24'h0, dout}, 32'h0);
        end
        chk("rst_key_ready", {31'h0, key_ready}, 32'h1);
        chk("rst_dsp_valid", {31'h0, dsp_valid}, 32'h0);
        @(posedge clk25); #1 rst = 1'b0;

        // 2: single lowercase key, folded
        push_key(7'h61);
        rd_chk("kbdcr_full", 2'd1, 8'h80);
        rd_chk("kbd_a", 2'd0, 8'hC1);
        rd_chk("kbdcr_empty", 2'd1, 8'h00);
        rd_chk("kbd_last", 2'd0, 8'h41);

        // 3: overflow with 5 pushes into depth 4
        for (int i = 0; i < 4; i++) push_key(7'h41 + 7'(i));
        chk("full_key_ready", {31'h0, key_ready}, 32'h0);
        push_key(7'h45);
        rd_chk("ovf_set", 2'd3, 8'h80);
        for (int i = 0; i < 4; i++) rd_chk($sformatf("kbd_ovf%0d", i), 2'd0, 8'hC1 + 8'(i));
        rd_chk("kbd_drained", 2'd0, 8'h44);
        bus_wr(2'd3, 8'h00);
        rd_chk("ovf_clr", 2'd3, 8'h00);

        // 4: display handshake and drop
        bus_wr(2'd2, 8'h8D);
        chk("dsp_valid", {31'h0, dsp_valid}, 32'h1);
        chk("dsp_data", {25'h0, dsp_data}, 32'h0D);
        rd_chk("dsp_busy", 2'd2, 8'h8D);
        bus_wr(2'd2, 8'h55);
        rd_chk("drop_set", 2'd3, 8'h40);
        chk("dsp_hold", {25'h0, dsp_data}, 32'h0D);
        dsp_ready = 1'b1;
        @(posedge clk25); #1 dsp_ready = 1'b0;
        rd_chk("dsp_idle", 2'd2, 8'h0D);
        bus_wr(2'd3, 8'h00);
        bus_wr(2'd2, 8'h01);
        dsp_ready = 1'b1;
        bus_wr(2'd2, 8'h02);
        dsp_ready = 1'b0;
        rd_chk("acc_wr_dsp", 2'd2, 8'h01);
        rd_chk("acc_wr_drop", 2'd3, 8'h40);
        bus_wr(2'd3, 8'h15);
        rd_chk("dspcr_wr", 2'd3, 8'h15);
        bus_wr(2'd3, 8'h00);

        // 5: push and pop together while full
        for (int i = 0; i < 4; i++) push_key(7'h50 + 7'(i));
        key_valid = 1'b1; key_data = 7'h54;
        bus_rd(2'd0, d);
        key_valid = 1'b0;
        chk("pp_head", {24'h0, d}, 32'hD0);
        chk("pp_still_full", {31'h0, key_ready}, 32'h0);
        rd_chk("pp_no_ovf", 2'd3, 8'h00);
        for (int i = 0; i < 4; i++) rd_chk($sformatf("kbd_pp%0d", i), 2'd0, 8'hD1 + 8'(i));
        rd_chk("empty_rd0", 2'd0, 8'h54);
        rd_chk("empty_rd1", 2'd0, 8'h54);
        rd_chk("empty_kbdcr", 2'd1, 8'h00);
        push_key(7'h78);
        rd_chk("kbd_x", 2'd0, 8'hD8);

        // no side effects without enable
        push_key(7'h31);
        enable = 1'b0;
        bus_rd(2'd0, d);
        enable = 1'b1;
        chk("noen_dout", {24'h0, d}, 32'hB1);
        rd_chk("noen_kept", 2'd1, 8'h80);
        rd_chk("kbd_1", 2'd0, 8'hB1);

        // 6: async reset mid-handshake
        bus_wr(2'd1, 8'h7F);
        push_key(7'h20);
        push_key(7'h21);
        bus_wr(2'd2, 8'h07);
        rd_chk("pre_kbdcr", 2'd1, 8'hFF);
        chk("pre_valid", {31'h0, dsp_valid}, 32'h1);
        #5 rst = 1'b1;
        #1;
        chk("ar_key_ready", {31'h0, key_ready}, 32'h1);
        chk("ar_dsp_valid", {31'h0, dsp_valid}, 32'h0);
        chk("ar_dsp_data", {25'h0, dsp_data}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            address = 2'(i);
            #1 chk($sformatf("ar_dout%0d", i), {24'h0, dout}, 32'h0);
        end
        @(posedge clk25); #1 rst = 1'b0;
        push_key(7'h6B);
        rd_chk("post_kbd", 2'd0, 8'hCB);
        rd_chk("post_kbdcr", 2'd1, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
